// File: rtl/stack_controller.sv
// Stack sequencer between the control FSM and the stack memory: owns sp, occupancy and
// error flags, and turns one req/ack push or pop into memory strobes.
module stack_controller #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int BASE       = 0,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              stack_clear,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              push_ack,
  output logic              pop_ack,
  output logic              req_err,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] SP_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_RD_LAT - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

  typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_WAIT} state_t;

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0]   sp_nxt;
  logic [ADDR_W:0]     count_nxt;
  logic                push_ack_nxt, pop_ack_nxt, req_err_nxt;
  logic                ovf_set, unf_set, capture, latch;
  logic [DATA_W-1:0]   wdata_q;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign ready     = (state == IDLE);
  assign mem_wdata = wdata_q;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    sp_nxt       = sp;
    count_nxt    = count;
    push_ack_nxt = 1'b0;
    pop_ack_nxt  = 1'b0;
    req_err_nxt  = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    capture      = 1'b0;
    latch        = 1'b0;
    mem_push     = 1'b0;
    mem_pop      = 1'b0;
    mem_addr     = sp;
    case (state)
      IDLE: begin
        if (stack_clear) begin
          sp_nxt    = BASE_A;
          count_nxt = '0;
        end else if (push_req) begin
          if (full) begin
            req_err_nxt = 1'b1;
            ovf_set     = 1'b1;
          end else begin
            latch     = 1'b1;
            state_nxt = PUSH;
          end
        end else if (pop_req) begin
          if (empty) begin
            req_err_nxt = 1'b1;
            unf_set     = 1'b1;
          end else begin
            state_nxt = POP_RD;
          end
        end
      end
      PUSH: begin
        mem_push     = 1'b1;
        sp_nxt       = sp + SP_ONE;
        count_nxt    = count + CNT_ONE;
        push_ack_nxt = 1'b1;
        state_nxt    = IDLE;
      end
      POP_RD: begin
        mem_pop      = 1'b1;
        mem_addr     = sp - SP_ONE;
        wait_cnt_nxt = LAT_LAST;
        state_nxt    = POP_WAIT;
      end
      POP_WAIT: begin
        // Wait out the memory read latency before taking mem_rdata.
        if (wait_cnt == '0) begin
          capture     = 1'b1;
          sp_nxt      = sp - SP_ONE;
          count_nxt   = count - CNT_ONE;
          pop_ack_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt - LAT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      sp        <= BASE_A;
      count     <= '0;
      push_ack  <= 1'b0;
      pop_ack   <= 1'b0;
      req_err   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      pop_data  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      sp        <= sp_nxt;
      count     <= count_nxt;
      push_ack  <= push_ack_nxt;
      pop_ack   <= pop_ack_nxt;
      req_err   <= req_err_nxt;
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
      if (capture) pop_data <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) wdata_q <= data_in;
  end

endmodule

// File: tb/tb_stack_controller.sv
// Randomized bench for stack_controller: a queue-based stack model plus a simple
// registered memory; directed scenarios first, then random operations.
module tb_stack_controller;
  localparam int DW = 32, AW = 10, DEP = 4, BASE = 0, LAT = 1;

  logic          clk, reset_n, push_req, pop_req, stack_clear, clr_err;
  logic [DW-1:0] data_in, pop_data, mem_wdata, mem_rdata;
  logic          ready, push_ack, pop_ack, req_err, full, empty, overflow, underflow;
  logic          mem_push, mem_pop;
  logic [AW-1:0] sp, mem_addr;
  logic [AW:0]   count;

  stack_controller #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BASE(BASE), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
    .stack_clear(stack_clear), .clr_err(clr_err), .data_in(data_in), .ready(ready),
    .push_ack(push_ack), .pop_ack(pop_ack), .req_err(req_err), .pop_data(pop_data),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow), .sp(sp),
    .count(count), .mem_addr(mem_addr), .mem_push(mem_push), .mem_pop(mem_pop),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack memory with a one-cycle registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_push) mem[mem_addr] <= mem_wdata;
    if (mem_pop)  mem_rdata     <= mem[mem_addr];
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor
  int            n_wr, n_rd;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  always @(negedge clk) begin
    if (reset_n && (mem_push || mem_pop)) begin
      check("strobe_excl", 64'(mem_push & mem_pop), 64'd0);
      if (mem_push) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (mem_pop)  begin n_rd++; rd_addr = mem_addr; end
    end
  end

  // Reference model
  logic [DW-1:0] stk[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_pop;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sp"},    64'(sp),        64'(BASE + stk.size()));
    check({tag, "_count"}, 64'(count),     64'(stk.size()));
    check({tag, "_full"},  64'(full),      64'(stk.size() == DEP));
    check({tag, "_empty"}, 64'(empty),     64'(stk.size() == 0));
    check({tag, "_ovf"},   64'(overflow),  64'(m_ovf));
    check({tag, "_unf"},   64'(underflow), 64'(m_unf));
    check({tag, "_pdata"}, 64'(pop_data),  64'(m_pop));
    check({tag, "_ready"}, 64'(ready),     64'd1);
  endtask

  // kind: 1 push_ack, 2 pop_ack, 3 req_err, 0 timeout
  task automatic wait_evt(output int n, output int kind);
    n = 0; kind = 0;
    while (kind == 0 && n < 12) begin
      tick(); n++;
      if (push_ack) kind = 1;
      else if (pop_ack) kind = 2;
      else if (req_err) kind = 3;
    end
  endtask

  task automatic op(input bit p, input bit q, input logic [DW-1:0] w, input string tag);
    int n, kind, exp_kind, exp_n;
    logic [AW-1:0] exp_addr;
    exp_addr = '0;
    if (p) begin
      if (stk.size() == DEP) begin exp_kind = 3; exp_n = 1; end
      else begin exp_kind = 1; exp_n = 2; exp_addr = AW'(BASE + stk.size()); end
    end else begin
      if (stk.size() == 0) begin exp_kind = 3; exp_n = 1; end
      else begin exp_kind = 2; exp_n = 2 + LAT; exp_addr = AW'(BASE + stk.size() - 1); end
    end
    n_wr = 0; n_rd = 0;
    push_req = p; pop_req = q; data_in = w;
    wait_evt(n, kind);
    push_req = 1'b0; pop_req = 1'b0; data_in = $urandom;
    check({tag, "_kind"}, 64'(kind), 64'(exp_kind));
    check({tag, "_lat"},  64'(n),    64'(exp_n));
    case (exp_kind)
      1: begin
        stk.push_back(w);
        check({tag, "_nwr"},   64'(n_wr),    64'd1);
        check({tag, "_waddr"}, 64'(wr_addr), 64'(exp_addr));
        check({tag, "_wdata"}, 64'(wr_data), 64'(w));
      end
      2: begin
        m_pop = stk.pop_back();
        check({tag, "_nrd"},   64'(n_rd),    64'd1);
        check({tag, "_raddr"}, 64'(rd_addr), 64'(exp_addr));
      end
      default: begin
        if (p) m_ovf = 1'b1; else m_unf = 1'b1;
        check({tag, "_nomem"}, 64'(n_wr + n_rd), 64'd0);
      end
    endcase
    check_state(tag);
  endtask

  initial begin
    int n, kind;
    reset_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; stack_clear = 1'b0;
    clr_err = 1'b0; data_in = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_pop = '0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    check("reset_acks", 64'({push_ack, pop_ack, req_err, mem_push, mem_pop}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single push, then LIFO pops
    op(1, 0, 32'hA5A5_0001, "t1");
    op(1, 0, 32'h1111_2222, "t2_push2");
    op(1, 0, 32'h3333_4444, "t2_push3");
    repeat (3) op(0, 1, '0, "t2_pop");

    // Underflow, clear, and same-cycle error beating clr_err
    op(0, 1, '0, "t3_err");
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    m_unf = 1'b0; m_ovf = 1'b0;
    check_state("t3_clr");
    op(0, 1, '0, "t3_seterr");
    clr_err = 1'b1;
    op(0, 1, '0, "t3_errwins");
    clr_err = 1'b0; m_ovf = 1'b0;
    tick();
    check_state("t3_after");

    // Overflow at DEPTH
    for (int i = 0; i < DEP; i++) op(1, 0, $urandom, "t4_fill");
    op(1, 0, 32'hDEAD_BEEF, "t4_ovf");
    check("t4_mem_top", 64'(mem[AW'(BASE + DEP - 1)]), 64'(stk[$]));

    // Push and pop together with one entry: push first, pop re-issues
    repeat (DEP - 1) op(0, 1, '0, "t5_drain");
    push_req = 1'b1; pop_req = 1'b1; data_in = 32'hC0DE_0005;
    wait_evt(n, kind);
    push_req = 1'b0;
    check("t5_push_kind", 64'(kind), 64'd1);
    check("t5_push_lat",  64'(n),    64'd2);
    check("t5_count2",    64'(count), 64'd2);
    stk.push_back(32'hC0DE_0005);
    wait_evt(n, kind);
    pop_req = 1'b0;
    check("t5_pop_kind", 64'(kind), 64'd2);
    check("t5_pop_lat",  64'(n),    64'(2 + LAT));
    m_pop = stk.pop_back();
    check_state("t5");

    // Async reset during POP_WAIT
    pop_req = 1'b1;
    tick(); tick();
    pop_req = 1'b0;
    reset_n = 1'b0;
    #1;
    stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_pop = '0;
    check_state("t6_rst");
    check("t6_rst_ack", 64'(pop_ack), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) begin
      tick();
      check("t6_noack", 64'(pop_ack | push_ack | req_err), 64'd0);
    end

    // stack_clear wins over a concurrent pop
    op(1, 0, $urandom, "t6_p1");
    op(1, 0, $urandom, "t6_p2");
    stack_clear = 1'b1; pop_req = 1'b1;
    tick();
    stack_clear = 1'b0; pop_req = 1'b0;
    stk.delete();
    check_state("t6_clear");
    tick();
    check("t6_clear_noack", 64'(pop_ack | push_ack | req_err), 64'd0);

    // Random operations
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3)      op(1, 0, $urandom, "rnd_push");
      else if (r <= 6) op(0, 1, '0, "rnd_pop");
      else if (r == 7) op(1, 1, $urandom, "rnd_both");
      else if (r == 8) begin
        stack_clear = 1'b1; tick(); stack_clear = 1'b0;
        stk.delete();
        check_state("rnd_clear");
      end else begin
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        check_state("rnd_clr_err");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
